// File: rtl/frame_compositor_pkg.sv
// frame_compositor_pkg: VGA 640x480 timing defaults, pixel/flag types,
// the game-core datagram width and the per-channel fade helper.
package frame_compositor_pkg;

    // Keep in step with MESSAGE_SIZE in the game core's constants.svh.
    localparam int MESSAGE_SIZE = 32;

    localparam int VGA_H_RES  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_RES  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Sync flags are kept active-high so an all-zero reset means "no sync".
    typedef struct packed {
        logic active;
        logic in_hsync;
        logic in_vsync;
    } scan_flags_t;

    // (c * (f + 1)) >> 4; f = 15 gives back c unchanged.
    function automatic logic [3:0] fade_chan(input logic [3:0] c,
                                             input logic [3:0] f);
        logic [7:0] prod;
        prod = {4'd0, c} * ({4'd0, f} + 8'd1);
        return prod[7:4];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick strobe, scan counters and raw sync flags.
// Ports: clk, rst -> pix_en, h_cnt, v_cnt, active, in_hsync, in_vsync.
module vga_timing_gen
    import frame_compositor_pkg::*;
#(
    parameter int H_RES   = VGA_H_RES,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_RES   = VGA_V_RES,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP,
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       in_hsync,
    output logic       in_vsync
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            logic [DIV_W-1:0] div_q, div_d;
            logic             pix_en_q, pix_en_d;

            // Strobe is registered: it rises on the clk where div_q
            // reaches CLK_DIV-1, so it is high exactly one clk in CLK_DIV.
            always_comb begin
                div_d    = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
                pix_en_d = (div_q == DIV_W'(CLK_DIV - 2));
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q    <= '0;
                    pix_en_q <= 1'b0;
                end else begin
                    div_q    <= div_d;
                    pix_en_q <= pix_en_d;
                end
            end

            assign pix_en = pix_en_q;
        end
    endgenerate

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt    = h_cnt_q;
    assign v_cnt    = v_cnt_q;
    assign active   = (h_cnt_q < 10'(H_RES)) && (v_cnt_q < 10'(V_RES));
    assign in_hsync = (h_cnt_q >= 10'(H_RES + H_FP)) &&
                      (h_cnt_q <  10'(H_RES + H_FP + H_SYNC));
    assign in_vsync = (v_cnt_q >= 10'(V_RES + V_FP)) &&
                      (v_cnt_q <  10'(V_RES + V_FP + V_SYNC));

endmodule

// File: rtl/frame_compositor.sv
// frame_compositor: VGA sprite-layer compositor with a frame-stable datagram.
// Inputs: clk, rst, datagram/datagram_valid, layer_mask, layer_valid,
// layer_pixel, bg_pixel (+ fade when COMPOSITOR_FADE_EN is defined).
// Outputs: frame_datagram, frame_tick, pix_en, h_cnt, v_cnt, active,
// vgaRed/vgaGreen/vgaBlue, hsync, vsync (active-low).
module frame_compositor
    import frame_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int H_RES      = VGA_H_RES,
    parameter int V_RES      = VGA_V_RES,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int CLK_DIV    = 4,
    parameter int LAYER_LAT  = 1,
    parameter int MSG_W      = MESSAGE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MSG_W-1:0]        datagram,
    input  logic                    datagram_valid,
    input  logic [NUM_LAYERS-1:0]   layer_mask,
    input  logic [NUM_LAYERS-1:0]   layer_valid,
    input  logic [12*NUM_LAYERS-1:0] layer_pixel,
    input  logic [11:0]             bg_pixel,
`ifdef COMPOSITOR_FADE_EN
    input  logic [3:0]              fade,
`endif
    output logic [MSG_W-1:0]        frame_datagram,
    output logic                    frame_tick,
    output logic                    pix_en,
    output logic [9:0]              h_cnt,
    output logic [9:0]              v_cnt,
    output logic                    active,
    output logic [3:0]              vgaRed,
    output logic [3:0]              vgaGreen,
    output logic [3:0]              vgaBlue,
    output logic                    hsync,
    output logic                    vsync
);

    logic in_hsync_w, in_vsync_w;

    vga_timing_gen #(
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .active  (active),
        .in_hsync(in_hsync_w),
        .in_vsync(in_vsync_w)
    );

    // Shadow and live (frame-stable) state.
    logic [MSG_W-1:0]      shadow_dg_q, shadow_dg_d;
    logic [MSG_W-1:0]      frame_dg_q, frame_dg_d;
    logic [NUM_LAYERS-1:0] shadow_mask_q, shadow_mask_d;
    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  capture;
`ifdef COMPOSITOR_FADE_EN
    logic [3:0]            shadow_fade_q, shadow_fade_d;
    logic [3:0]            fade_q, fade_d;
`endif

    assign capture = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'(V_RES));

    // Capture loads from shadow_*_d, so a datagram arriving on the
    // capture clk bypasses straight into the live registers.
    always_comb begin
        shadow_dg_d   = datagram_valid ? datagram : shadow_dg_q;
        shadow_mask_d = datagram_valid ? layer_mask : shadow_mask_q;
        frame_dg_d    = capture ? shadow_dg_d : frame_dg_q;
        mask_d        = capture ? shadow_mask_d : mask_q;
        frame_tick_d  = capture;
`ifdef COMPOSITOR_FADE_EN
        shadow_fade_d = datagram_valid ? fade : shadow_fade_q;
        fade_d        = capture ? shadow_fade_d : fade_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_dg_q   <= '0;
            shadow_mask_q <= '0;
            frame_dg_q    <= '0;
            mask_q        <= '0;
            frame_tick_q  <= 1'b0;
`ifdef COMPOSITOR_FADE_EN
            shadow_fade_q <= '0;
            fade_q        <= '0;
`endif
        end else begin
            shadow_dg_q   <= shadow_dg_d;
            shadow_mask_q <= shadow_mask_d;
            frame_dg_q    <= frame_dg_d;
            mask_q        <= mask_d;
            frame_tick_q  <= frame_tick_d;
`ifdef COMPOSITOR_FADE_EN
            shadow_fade_q <= shadow_fade_d;
            fade_q        <= fade_d;
`endif
        end
    end

    assign frame_datagram = frame_dg_q;
    assign frame_tick     = frame_tick_q;

    // Delay scan flags by LAYER_LAT ticks to line up with layer data.
    scan_flags_t scan_now, scan_dly;
    assign scan_now = scan_flags_t'({active, in_hsync_w, in_vsync_w});

    generate
        if (LAYER_LAT == 0) begin : g_nolat
            assign scan_dly = scan_now;
        end else begin : g_lat
            scan_flags_t dly_q [LAYER_LAT];
            scan_flags_t dly_d [LAYER_LAT];

            always_comb begin
                for (int i = 0; i < LAYER_LAT; i++) dly_d[i] = dly_q[i];
                if (pix_en) begin
                    dly_d[0] = scan_now;
                    for (int i = 1; i < LAYER_LAT; i++) dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= '0;
                end else begin
                    for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= dly_d[i];
                end
            end

            assign scan_dly = dly_q[LAYER_LAT-1];
        end
    endgenerate

    // Walk from the top index down so the lowest enabled opaque layer wins.
    rgb444_t winner, shaded;

    always_comb begin
        winner = rgb444_t'(bg_pixel);
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (layer_valid[k] && mask_q[k]) begin
                winner = rgb444_t'(layer_pixel[12*k +: 12]);
            end
        end
    end

`ifdef COMPOSITOR_FADE_EN
    always_comb begin
        shaded.r = fade_chan(winner.r, fade_q);
        shaded.g = fade_chan(winner.g, fade_q);
        shaded.b = fade_chan(winner.b, fade_q);
    end
`else
    assign shaded = winner;
`endif

    rgb444_t rgb_q, rgb_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix_en) begin
            rgb_d   = scan_dly.active ? shaded : '0;
            hsync_d = ~scan_dly.in_hsync;
            vsync_d = ~scan_dly.in_vsync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vgaRed   = rgb_q.r;
    assign vgaGreen = rgb_q.g;
    assign vgaBlue  = rgb_q.b;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule

// File: tb/tb_frame_compositor.sv
// tb_frame_compositor: directed + random checks of frame_compositor against
// an arithmetic scan/composite model; a small-timing and a default instance.
module tb_frame_compositor;
    import frame_compositor_pkg::*;

    localparam int MW  = MESSAGE_SIZE;
    localparam int DIV = 4;
    localparam int LAT = 1;

    localparam int S_HR = 16, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VR = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [MW-1:0] datagram;
    logic          datagram_valid;
    logic [3:0]    layer_mask;
    logic [3:0]    layer_valid;
    logic [47:0]   layer_pixel;
    logic [11:0]   bg_pixel;
`ifdef COMPOSITOR_FADE_EN
    logic [3:0]    fade;
`endif

    logic [MW-1:0] o_fd  [2];
    logic          o_tick[2];
    logic          o_pe  [2];
    logic [9:0]    o_h   [2];
    logic [9:0]    o_v   [2];
    logic          o_act [2];
    logic [3:0]    o_r   [2];
    logic [3:0]    o_g   [2];
    logic [3:0]    o_b   [2];
    logic          o_hs  [2];
    logic          o_vs  [2];

    frame_compositor #(
        .NUM_LAYERS(4),
        .H_RES(S_HR), .V_RES(S_VR),
        .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .CLK_DIV(DIV), .LAYER_LAT(LAT), .MSG_W(MW)
    ) u_small (
        .clk(clk), .rst(rst),
        .datagram(datagram), .datagram_valid(datagram_valid),
        .layer_mask(layer_mask), .layer_valid(layer_valid),
        .layer_pixel(layer_pixel), .bg_pixel(bg_pixel),
`ifdef COMPOSITOR_FADE_EN
        .fade(fade),
`endif
        .frame_datagram(o_fd[0]), .frame_tick(o_tick[0]),
        .pix_en(o_pe[0]), .h_cnt(o_h[0]), .v_cnt(o_v[0]),
        .active(o_act[0]),
        .vgaRed(o_r[0]), .vgaGreen(o_g[0]), .vgaBlue(o_b[0]),
        .hsync(o_hs[0]), .vsync(o_vs[0])
    );

    frame_compositor u_dflt (
        .clk(clk), .rst(rst),
        .datagram(datagram), .datagram_valid(datagram_valid),
        .layer_mask(layer_mask), .layer_valid(layer_valid),
        .layer_pixel(layer_pixel), .bg_pixel(bg_pixel),
`ifdef COMPOSITOR_FADE_EN
        .fade(fade),
`endif
        .frame_datagram(o_fd[1]), .frame_tick(o_tick[1]),
        .pix_en(o_pe[1]), .h_cnt(o_h[1]), .v_cnt(o_v[1]),
        .active(o_act[1]),
        .vgaRed(o_r[1]), .vgaGreen(o_g[1]), .vgaBlue(o_b[1]),
        .hsync(o_hs[1]), .vsync(o_vs[1])
    );

    // Clocks since the last reset release.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int vecs = 0;
    int errs = 0;

    logic [MW-1:0] m_sh_dg;
    logic [3:0]    m_sh_mask;
    logic [3:0]    m_sh_fade;
    logic [MW-1:0] m_fd   [2];
    logic [3:0]    m_mask [2];
    logic [3:0]    m_fade [2];
    logic [11:0]   m_rgb  [2];

    task automatic chk(input int i, input string tag,
                       input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h",
                   tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh_dg   = '0;
        m_sh_mask = '0;
`ifdef COMPOSITOR_FADE_EN
        m_sh_fade = 4'd0;
`else
        m_sh_fade = 4'd15;
`endif
        for (int i = 0; i < 2; i++) begin
            m_fd[i]   = '0;
            m_mask[i] = '0;
            m_fade[i] = m_sh_fade;
            m_rgb[i]  = '0;
        end
    endtask

    // Lowest enabled valid layer, else background, then fade scaling.
    function automatic logic [11:0] expect_pixel(input logic [3:0] mk,
                                                 input logic [3:0] fd);
        logic [11:0] w;
        int scale;
        w = bg_pixel;
        for (int k = 0; k < 4; k++) begin
            if (layer_valid[k] && mk[k]) begin
                w = layer_pixel[12*k +: 12];
                break;
            end
        end
        scale = int'(fd) + 1;
        for (int ch = 0; ch < 3; ch++)
            w[4*ch +: 4] = 4'((int'(w[4*ch +: 4]) * scale) / 16);
        return w;
    endfunction

    task automatic reset_checks();
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_pix_en", 64'(o_pe[i]), 64'(0));
            chk(i, "rst_h_cnt", 64'(o_h[i]), 64'(0));
            chk(i, "rst_v_cnt", 64'(o_v[i]), 64'(0));
            chk(i, "rst_active", 64'(o_act[i]), 64'(1));
            chk(i, "rst_hsync", 64'(o_hs[i]), 64'(1));
            chk(i, "rst_vsync", 64'(o_vs[i]), 64'(1));
            chk(i, "rst_rgb", 64'({o_r[i], o_g[i], o_b[i]}), 64'(0));
            chk(i, "rst_frame_tick", 64'(o_tick[i]), 64'(0));
            chk(i, "rst_frame_dg", 64'(o_fd[i]), 64'(0));
        end
    endtask

    task automatic model_check(input int i);
        int hr, hfp, hsw, hbp, vr, vfp, vsw, vbp, ht, vt;
        int n, c, hc, vc;
        bit tick, cap, act_d, hs_d, vs_d;
        hr  = (i == 0) ? S_HR  : 640;
        hfp = (i == 0) ? S_HFP : 16;
        hsw = (i == 0) ? S_HS  : 96;
        hbp = (i == 0) ? S_HBP : 48;
        vr  = (i == 0) ? S_VR  : 480;
        vfp = (i == 0) ? S_VFP : 10;
        vsw = (i == 0) ? S_VS  : 2;
        vbp = (i == 0) ? S_VBP : 33;
        ht  = hr + hfp + hsw + hbp;
        vt  = vr + vfp + vsw + vbp;
        n    = cyc / DIV;
        tick = (cyc % DIV == 0) && (cyc > 0);
        // Scan position whose flags/pixel are now on the outputs.
        c     = n - 1 - LAT;
        hc    = (c >= 0) ? c % ht : 0;
        vc    = (c >= 0) ? (c / ht) % vt : 0;
        act_d = (c >= 0) && hc < hr && vc < vr;
        hs_d  = (c >= 0) && hc >= hr + hfp && hc < hr + hfp + hsw;
        vs_d  = (c >= 0) && vc >= vr + vfp && vc < vr + vfp + vsw;
        cap   = tick && ((n - 1) % (ht * vt) == vr * ht);
        if (tick) m_rgb[i] = act_d ? expect_pixel(m_mask[i], m_fade[i]) : 12'h000;
        if (cap) begin
            m_fd[i]   = datagram_valid ? datagram : m_sh_dg;
            m_mask[i] = datagram_valid ? layer_mask : m_sh_mask;
`ifdef COMPOSITOR_FADE_EN
            m_fade[i] = datagram_valid ? fade : m_sh_fade;
`endif
        end
        chk(i, "pix_en", 64'(o_pe[i]), 64'(cyc % DIV == DIV - 1));
        chk(i, "h_cnt", 64'(o_h[i]), 64'(n % ht));
        chk(i, "v_cnt", 64'(o_v[i]), 64'((n / ht) % vt));
        chk(i, "active", 64'(o_act[i]),
            64'((n % ht) < hr && ((n / ht) % vt) < vr));
        chk(i, "hsync", 64'(o_hs[i]), 64'(!hs_d));
        chk(i, "vsync", 64'(o_vs[i]), 64'(!vs_d));
        chk(i, "rgb", 64'({o_r[i], o_g[i], o_b[i]}), 64'(m_rgb[i]));
        chk(i, "frame_tick", 64'(o_tick[i]), 64'(cap));
        chk(i, "frame_dg", 64'(o_fd[i]), 64'(m_fd[i]));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_check(i);
        if (datagram_valid) begin
            m_sh_dg   = datagram;
            m_sh_mask = layer_mask;
`ifdef COMPOSITOR_FADE_EN
            m_sh_fade = fade;
`endif
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic send(input logic [MW-1:0] dg, input logic [3:0] mk,
                        input logic [3:0] fd);
        datagram       = dg;
        layer_mask     = mk;
        datagram_valid = 1'b1;
`ifdef COMPOSITOR_FADE_EN
        fade           = fd;
`else
        if (fd != 4'hF) $display("note: fade %0h unused", fd);
`endif
        step();
        datagram_valid = 1'b0;
    endtask

    logic [MW-1:0] dg_b, dg_c;
    logic [11:0]   fade_exp;

    initial begin
        datagram       = '0;
        datagram_valid = 1'b0;
        layer_mask     = '0;
        layer_valid    = '0;
        layer_pixel    = '0;
        bg_pixel       = 12'h00F;
`ifdef COMPOSITOR_FADE_EN
        fade           = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;

        // Datagram A mid-frame, B before blanking; B is captured at 556.
        run_to(99);
        send(MW'($urandom()), 4'hF, 4'h3);
        dg_b = MW'($urandom());
        run_to(399);
        send(dg_b, 4'hF, 4'hF);
        run_to(555);
        chk(0, "dg_before_capture", 64'(o_fd[0]), 64'(0));
        step();
        chk(0, "dg_at_capture", 64'(o_fd[0]), 64'(dg_b));
        chk(0, "tick_at_capture", 64'(o_tick[0]), 64'(1));
        step();
        chk(0, "tick_one_clk", 64'(o_tick[0]), 64'(0));

        // No layer valid: background in active area, black in blanking.
        run_to(1000);
        chk(0, "bg_blank", 64'({o_r[0], o_g[0], o_b[0]}), 64'(12'h000));
        run_to(1040);
        chk(0, "bg_active", 64'({o_r[0], o_g[0], o_b[0]}), 64'(12'h00F));

        // Layers 1 and 2 valid, full mask: layer 1 wins.
        run_to(1100);
        layer_valid = 4'b0110;
        layer_pixel = {12'h123, 12'h0F0, 12'hF00, 12'h456};
        run_to(1216);
        chk(0, "prio_l1", 64'({o_r[0], o_g[0], o_b[0]}), 64'(12'hF00));

        // Mask 4'hD drops layer 1 from the next frame on.
        run_to(1299);
        send(MW'($urandom()), 4'hD, 4'hF);
        run_to(2136);
        chk(0, "mask_l2", 64'({o_r[0], o_g[0], o_b[0]}), 64'(12'h0F0));

        // Datagram C on the capture clk itself, fade 7 on white.
        run_to(2200);
        layer_valid = 4'b0001;
        layer_pixel = {12'h123, 12'h0F0, 12'hF00, 12'hFFF};
        dg_c = MW'($urandom());
        run_to(2395);
        send(dg_c, 4'h1, 4'h7);
        chk(0, "dg_bypass", 64'(o_fd[0]), 64'(dg_c));
`ifdef COMPOSITOR_FADE_EN
        fade_exp = 12'h777;
`else
        fade_exp = 12'hFFF;
`endif
        run_to(3056);
        chk(0, "fade_white", 64'({o_r[0], o_g[0], o_b[0]}), 64'(fade_exp));

        // Mid-frame reset restarts timing and clears captured state.
        run_to(3100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        reset_checks();
        rst = 1'b0;

        // Random layers, background and datagrams against the model.
        for (int k = 0; k < 7000; k++) begin
            layer_valid = 4'($urandom());
            layer_pixel = 48'({$urandom(), $urandom()});
            bg_pixel    = 12'($urandom());
            if ($urandom_range(0, 149) == 0) begin
                datagram       = MW'($urandom());
                layer_mask     = 4'($urandom());
                datagram_valid = 1'b1;
`ifdef COMPOSITOR_FADE_EN
                fade           = 4'($urandom());
`endif
            end else begin
                datagram_valid = 1'b0;
            end
            step();
        end
        datagram_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
